// File: rtl/strobe_gen_pkg.sv
// strobe_gen_pkg: shared channel state, mode
// constants and default sizes for strobe_gen_multi.
package strobe_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    PULSE = 2'd2
  } ch_state_e;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 15;
  localparam int DEF_DIV_W  = 16;
  localparam int DEF_PW_W   = 4;

endpackage

// File: rtl/strobe_channel.sv
// strobe_channel: one strobe channel with its
// IDLE/COUNT/PULSE FSM, phase and width counters.
module strobe_channel
  import strobe_gen_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int PW_W  = DEF_PW_W
) (
  input  logic             SlowClock,
  input  logic             ResetN,
  input  logic             sync,
  input  logic             enable,
  input  logic             one_shot,
  input  logic             start,
  input  logic [DIV_W-1:0] period,
  input  logic [PW_W-1:0]  width,
  output logic             strobe,
  output logic             busy
);

  ch_state_e state;
  ch_state_e state_n;

  logic [DIV_W-1:0] ph;
  logic [DIV_W-1:0] ph_n;
  logic [DIV_W-1:0] ps;
  logic [DIV_W-1:0] ps_n;
  logic [PW_W-1:0]  wc;
  logic [PW_W-1:0]  wc_n;
  logic [PW_W-1:0]  ws;
  logic [PW_W-1:0]  ws_n;
  logic             strobe_n;

  logic [PW_W-1:0]  weff;
  logic             running;
  logic             hit;
  logic             is_os;
  logic             launch;

  logic kill;
  logic enter;
  logic resync;
  logic trig;
  logic step;

  assign weff    = (width == '0) ? PW_W'(1) : width;
  assign running = (state != IDLE);
  assign hit     = (ph == ps - DIV_W'(1));
  assign is_os   = (one_shot == MODE_ONESHOT);
  assign launch  = (period != '0) &&
                   ((one_shot == MODE_PERIODIC) || start);

  // Mutually exclusive actions, in priority order.
  assign kill   = !enable;
  assign enter  = enable && !running && launch;
  assign resync = enable && running && sync;
  assign trig   = enable && running && !sync && hit &&
                  !(is_os && state == PULSE);
  assign step   = enable && running && !sync && !trig;

  always_ff @(posedge SlowClock or negedge ResetN) begin
    if (!ResetN) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (1'b1)
      kill:   state_n = IDLE;
      enter:  state_n = COUNT;
      resync: state_n = COUNT;
      trig:   state_n = PULSE;
      step: begin
        if (state == PULSE && wc == '0) begin
          state_n = is_os ? IDLE : COUNT;
        end
      end
      default: state_n = state;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    unique case (state)
      COUNT, PULSE: busy = 1'b1;
      default:      busy = 1'b0;
    endcase
  end

  always_comb begin
    ph_n     = ph;
    wc_n     = wc;
    ps_n     = ps;
    ws_n     = ws;
    strobe_n = strobe;
    unique case (1'b1)
      kill: begin
        ph_n     = '0;
        strobe_n = 1'b0;
      end
      enter, resync: begin
        ph_n     = '0;
        strobe_n = 1'b0;
        ps_n     = period;
        ws_n     = weff;
      end
      trig: begin
        // Shadow width applies now; new config from next period.
        ph_n     = '0;
        wc_n     = ws - PW_W'(1);
        strobe_n = 1'b1;
        ps_n     = period;
        ws_n     = weff;
      end
      step: begin
        ph_n = hit ? '0 : ph + DIV_W'(1);
        if (state == PULSE) begin
          if (wc != '0) begin
            wc_n = wc - PW_W'(1);
          end else begin
            strobe_n = 1'b0;
          end
        end
      end
      default: begin
        ph_n = ph;
      end
    endcase
  end

  always_ff @(posedge SlowClock or negedge ResetN) begin
    if (!ResetN) begin
      ph     <= '0;
      wc     <= '0;
      ps     <= '0;
      ws     <= '0;
      strobe <= 1'b0;
    end else begin
      ph     <= ph_n;
      wc     <= wc_n;
      ps     <= ps_n;
      ws     <= ws_n;
      strobe <= strobe_n;
    end
  end

endmodule

// File: rtl/strobe_gen_multi.sv
// strobe_gen_multi: free-running counter plus NUM_CH
// programmable strobe channels with shared phase-align.
module strobe_gen_multi
  import strobe_gen_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int DIV_W  = DEF_DIV_W,
  parameter int PW_W   = DEF_PW_W
) (
  input  logic                    SlowClock,
  input  logic                    ResetN,
  input  logic                    Sync,
  input  logic [NUM_CH-1:0]       ChEnable,
  input  logic [NUM_CH-1:0]       ChOneShot,
  input  logic [NUM_CH-1:0]       ChStart,
  input  logic [NUM_CH*DIV_W-1:0] ChPeriod,
  input  logic [NUM_CH*PW_W-1:0]  ChWidth,
  output logic [CNT_W-1:0]        Counter,
  output logic [NUM_CH-1:0]       Strobe,
  output logic [NUM_CH-1:0]       ChBusy
);

  always_ff @(posedge SlowClock or negedge ResetN) begin
    if (!ResetN) begin
      Counter <= '0;
    end else if (Sync) begin
      Counter <= '0;
    end else begin
      Counter <= Counter + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    strobe_channel #(
      .DIV_W (DIV_W),
      .PW_W  (PW_W)
    ) u_ch (
      .SlowClock (SlowClock),
      .ResetN    (ResetN),
      .sync      (Sync),
      .enable    (ChEnable[i]),
      .one_shot  (ChOneShot[i]),
      .start     (ChStart[i]),
      .period    (ChPeriod[i*DIV_W +: DIV_W]),
      .width     (ChWidth[i*PW_W +: PW_W]),
      .strobe    (Strobe[i]),
      .busy      (ChBusy[i])
    );
  end

endmodule

// File: tb/tb_strobe_gen_multi.sv
// tb_strobe_gen_multi: directed bench with a countdown
// model of every channel, checked each cycle.
module tb_strobe_gen_multi;

  logic        SlowClock;
  logic        ResetN;
  logic        Sync;
  logic [3:0]  ChEnable;
  logic [3:0]  ChOneShot;
  logic [3:0]  ChStart;
  logic [63:0] ChPeriod;
  logic [15:0] ChWidth;
  logic [14:0] Counter;
  logic [3:0]  Strobe;
  logic [3:0]  ChBusy;

  strobe_gen_multi dut (
    .SlowClock (SlowClock),
    .ResetN    (ResetN),
    .Sync      (Sync),
    .ChEnable  (ChEnable),
    .ChOneShot (ChOneShot),
    .ChStart   (ChStart),
    .ChPeriod  (ChPeriod),
    .ChWidth   (ChWidth),
    .Counter   (Counter),
    .Strobe    (Strobe),
    .ChBusy    (ChBusy)
  );

  initial SlowClock = 1'b0;
  always #5 SlowClock = ~SlowClock;

  int n_pass;
  int n_tot;
  int since_rst;

  // Model: cycles until next rise, remaining high cycles.
  int m_busy[4];
  int m_fired[4];
  int m_to[4];
  int m_rem[4];
  int m_p[4];
  int m_w[4];
  int m_cnt;

  logic [31:0] rec;
  logic [31:0] rb;
  logic [31:0] r0;
  logic [31:0] r2;
  logic [31:0] r3;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_busy[i]  = 0;
      m_fired[i] = 0;
      m_to[i]    = 0;
      m_rem[i]   = 0;
      m_p[i]     = 0;
      m_w[i]     = 0;
    end
    m_cnt = 0;
  endtask

  task automatic model_step();
    for (int i = 0; i < 4; i++) begin
      int p;
      int w;
      p = int'(ChPeriod[i*16 +: 16]);
      w = int'(ChWidth[i*4 +: 4]);
      if (w == 0) w = 1;
      if (!ChEnable[i]) begin
        m_busy[i] = 0;
        m_rem[i]  = 0;
      end else if (m_busy[i] == 0) begin
        if (p != 0 && (!ChOneShot[i] || ChStart[i])) begin
          m_busy[i]  = 1;
          m_fired[i] = 0;
          m_to[i]    = p;
          m_p[i]     = p;
          m_w[i]     = w;
          m_rem[i]   = 0;
        end
      end else if (Sync) begin
        m_to[i]    = p;
        m_p[i]     = p;
        m_w[i]     = w;
        m_rem[i]   = 0;
        m_fired[i] = 0;
      end else begin
        m_to[i]--;
        if (m_to[i] == 0 && !(ChOneShot[i] && m_fired[i] != 0)) begin
          m_rem[i]   = m_w[i];
          m_fired[i] = 1;
          m_p[i]     = p;
          m_w[i]     = w;
          m_to[i]    = p;
        end else begin
          if (m_to[i] == 0) m_to[i] = m_p[i];
          if (m_rem[i] > 0) begin
            m_rem[i]--;
            if (m_rem[i] == 0 && ChOneShot[i]) m_busy[i] = 0;
          end
        end
      end
    end
    m_cnt = Sync ? 0 : (m_cnt + 1) % 32768;
  endtask

  task automatic check_all();
    logic [3:0] es;
    logic [3:0] eb;
    for (int i = 0; i < 4; i++) begin
      es[i] = (m_rem[i] > 0);
      eb[i] = (m_busy[i] != 0);
    end
    chk("strobe", 32'(Strobe), 32'(es));
    chk("busy", 32'(ChBusy), 32'(eb));
    chk("counter", 32'(Counter), 32'(m_cnt));
  endtask

  task automatic tick();
    @(posedge SlowClock);
    model_step();
    since_rst++;
    @(negedge SlowClock);
    check_all();
  endtask

  task automatic set_ch(input int i, input logic en, input logic os,
                        input int p, input int w);
    ChEnable[i]        = en;
    ChOneShot[i]       = os;
    ChPeriod[i*16 +: 16] = 16'(p);
    ChWidth[i*4 +: 4]    = 4'(w);
  endtask

  initial begin
    n_pass    = 0;
    n_tot     = 0;
    since_rst = 0;
    ResetN    = 1'b0;
    Sync      = 1'b0;
    ChEnable  = '0;
    ChOneShot = '0;
    ChStart   = '0;
    ChPeriod  = '0;
    ChWidth   = '0;
    model_reset();
    repeat (2) @(negedge SlowClock);
    chk("rst_strobe", 32'(Strobe), 32'd0);
    chk("rst_busy", 32'(ChBusy), 32'd0);
    chk("rst_cnt", 32'(Counter), 32'd0);
    ResetN    = 1'b1;
    since_rst = 0;

    // Reset in the middle of a pulse
    set_ch(0, 1'b1, 1'b0, 8, 3);
    repeat (9) tick();
    chk("p8_rise", 32'(Strobe[0]), 32'd1);
    tick();
    ResetN = 1'b0;
    model_reset();
    #1;
    chk("arst_strobe", 32'(Strobe), 32'd0);
    chk("arst_busy", 32'(ChBusy), 32'd0);
    chk("arst_cnt", 32'(Counter), 32'd0);
    @(negedge SlowClock);
    ResetN    = 1'b1;
    since_rst = 0;
    rec = '0;
    for (int j = 0; j <= 8; j++) begin
      tick();
      rec[j] = Strobe[0];
    end
    chk("p8_after_rst", rec, 32'h100);
    set_ch(0, 1'b0, 1'b0, 0, 0);
    tick();

    // Periodic P=5 W=2
    set_ch(0, 1'b1, 1'b0, 5, 2);
    rec = '0;
    for (int j = 0; j <= 16; j++) begin
      tick();
      rec[j] = Strobe[0];
    end
    chk("per_p5w2", rec, 32'h18C60);
    set_ch(0, 1'b0, 1'b0, 0, 0);
    tick();

    // One-shot P=4 W=3, second Start while busy
    set_ch(1, 1'b1, 1'b1, 4, 3);
    ChStart[1] = 1'b1;
    rec = '0;
    rb  = '0;
    for (int j = 0; j <= 10; j++) begin
      tick();
      rec[j] = Strobe[1];
      rb[j]  = ChBusy[1];
      ChStart[1] = (j == 1);
    end
    chk("os_strobe", rec, 32'h70);
    chk("os_busy", rb, 32'h7F);
    set_ch(1, 1'b0, 1'b0, 0, 0);
    tick();

    // Width corner cases side by side
    set_ch(2, 1'b1, 1'b0, 3, 5);
    set_ch(3, 1'b1, 1'b0, 1, 0);
    set_ch(0, 1'b1, 1'b0, 4, 0);
    set_ch(1, 1'b1, 1'b0, 0, 3);
    r0 = '0;
    r2 = '0;
    r3 = '0;
    rb = '0;
    for (int j = 0; j <= 12; j++) begin
      tick();
      r0[j] = Strobe[0];
      r2[j] = Strobe[2];
      r3[j] = Strobe[3];
      rb[j] = ChBusy[1];
    end
    chk("w_ge_p", r2, 32'h1FF8);
    chk("p_one", r3, 32'h1FFE);
    chk("w_zero", r0, 32'h1110);
    chk("p_zero_busy", rb, 32'h0);
    ChEnable = '0;
    tick();

    // Reconfigure mid-period, then disable during a pulse
    set_ch(0, 1'b1, 1'b0, 6, 1);
    rec = '0;
    for (int j = 0; j <= 16; j++) begin
      tick();
      rec[j] = Strobe[0];
      if (j == 3) ChPeriod[15:0] = 16'd10;
    end
    chk("reconfig", rec, 32'h10040);
    ChEnable[0] = 1'b0;
    tick();
    chk("dis_strobe", 32'(Strobe[0]), 32'd0);
    chk("dis_busy", 32'(ChBusy[0]), 32'd0);

    // Counter wrap
    while (since_rst < 32767) tick();
    chk("cnt_max", 32'(Counter), 32'h7FFF);
    tick();
    chk("cnt_wrap", 32'(Counter), 32'd0);

    // Sync realigns two staggered channels
    set_ch(0, 1'b1, 1'b0, 7, 2);
    set_ch(3, 1'b1, 1'b1, 7, 2);
    tick();
    tick();
    tick();
    set_ch(1, 1'b1, 1'b0, 7, 2);
    tick();
    tick();
    Sync = 1'b1;
    tick();
    Sync = 1'b0;
    chk("sync_cnt0", 32'(Counter), 32'd0);
    rec = '0;
    rb  = '0;
    for (int j = 1; j <= 8; j++) begin
      tick();
      rec[j] = Strobe[0];
      rb[j]  = Strobe[1];
      if (j == 1) chk("sync_cnt1", 32'(Counter), 32'd1);
    end
    chk("sync_ch0", rec, 32'h180);
    chk("sync_ch1", rb, 32'h180);
    chk("sync_idle", 32'(ChBusy[3]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
